// File: rtl/turn_switch_cond_if.sv
// Switch-side and sequencer-side signals of the turn-switch conditioner.
// The slave modport is the conditioner; the master drives raw switches and observes the mode.
interface turn_switch_cond_if;
  logic sw_left;
  logic sw_right;
  logic sw_hazard;
  logic L;
  logic R;
  logic H;
  logic step_tick;
  logic mode_chg;

  modport master (
    output sw_left,
    output sw_right,
    output sw_hazard,
    input  L,
    input  R,
    input  H,
    input  step_tick,
    input  mode_chg
  );

  modport slave (
    input  sw_left,
    input  sw_right,
    input  sw_hazard,
    output L,
    output R,
    output H,
    output step_tick,
    output mode_chg
  );
endinterface

// File: rtl/turn_switch_cond.sv
// Synchronizes, debounces and arbitrates turn/hazard switches into a one-hot L/R/H mode plus
// a step_tick pacing strobe. Define TURN_LATCH_EN for momentary push-button left/right latching.
module turn_switch_cond #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned STEP_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst_n,
  turn_switch_cond_if.slave sw_if
);

  localparam int unsigned TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StLeft, StRight, StHazard} mode_e;

  // Bit order everywhere: 0 = left, 1 = right, 2 = hazard.
  logic [2:0]  raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  deb_q, deb_d;
  logic [15:0] deb_cnt_q [3];
  logic [15:0] deb_cnt_d [3];

  mode_e       mode_q, mode_d;
  logic        l_q, r_q, h_q;
  logic        tick_q, mode_chg_q;
  logic [TW-1:0] tick_cnt_q;

  assign raw = {sw_if.sw_hazard, sw_if.sw_right, sw_if.sw_left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // The level flips on the DEB_CYCLES-th consecutive differing sample.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == 16'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

`ifdef TURN_LATCH_EN
  mode_e      lat_q, lat_d;
  logic [1:0] deb_prev_q;
  logic [1:0] rise;

  assign rise = deb_q[1:0] & ~deb_prev_q;

  // Presses while hazard is active are ignored so the pre-hazard turn state is restored.
  always_comb begin
    lat_d = lat_q;
    if (!deb_q[2]) begin
      if (rise[0] && !rise[1]) begin
        lat_d = (lat_q == StLeft) ? StIdle : StLeft;
      end else if (rise[1] && !rise[0]) begin
        lat_d = (lat_q == StRight) ? StIdle : StRight;
      end
    end
    mode_d = deb_q[2] ? StHazard : lat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q      <= StIdle;
      deb_prev_q <= '0;
    end else begin
      lat_q      <= lat_d;
      deb_prev_q <= deb_q[1:0];
    end
  end
`else
  always_comb begin
    mode_d = StIdle;
    if (deb_q[2]) begin
      mode_d = StHazard;
    end else if (deb_q[0] && !deb_q[1]) begin
      mode_d = StLeft;
    end else if (deb_q[1] && !deb_q[0]) begin
      mode_d = StRight;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= StIdle;
      l_q        <= 1'b0;
      r_q        <= 1'b0;
      h_q        <= 1'b0;
      mode_chg_q <= 1'b0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      l_q        <= (mode_d == StLeft);
      r_q        <= (mode_d == StRight);
      h_q        <= (mode_d == StHazard);
      mode_chg_q <= (mode_d != mode_q);
      if (mode_d != mode_q || mode_d == StIdle) begin
        tick_q     <= 1'b0;
        tick_cnt_q <= '0;
      end else if (tick_cnt_q == TW'(STEP_CYCLES - 1)) begin
        tick_q     <= 1'b1;
        tick_cnt_q <= '0;
      end else begin
        tick_q     <= 1'b0;
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign sw_if.L         = l_q;
  assign sw_if.R         = r_q;
  assign sw_if.H         = h_q;
  assign sw_if.step_tick = tick_q;
  assign sw_if.mode_chg  = mode_chg_q;

endmodule

// File: tb/tb_turn_switch_cond.sv
// Bench for turn_switch_cond: a cycle-level behavioural model checked every cycle, plus
// directed scenarios with literal expectations (latch scenarios when TURN_LATCH_EN is defined).
module tb_turn_switch_cond;
  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pin = 3'b000;  // 0 left, 1 right, 2 hazard
  int         checks = 0;
  int         errors = 0;

  turn_switch_cond_if sw_if ();

  assign sw_if.sw_left   = pin[0];
  assign sw_if.sw_right  = pin[1];
  assign sw_if.sw_hazard = pin[2];

  turn_switch_cond #(
    .DEB_CYCLES (DEB),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw_if(sw_if.slave)
  );

  always #5 clk = ~clk;

  wire [4:0] dut_vec = {sw_if.L, sw_if.R, sw_if.H, sw_if.step_tick, sw_if.mode_chg};

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {L,R,H,tick,chg}=%b expected %b", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 left, 2 right, 3 hazard
  bit [2:0] m_s1, m_s2, m_deb, m_prev;
  int       m_run [3];
  int       m_mode, m_lat, m_since;
  bit       m_tick, m_chg;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_mode = 0; m_lat = 0; m_since = 0; m_tick = 0; m_chg = 0;
      end else begin
        int nm;
`ifdef TURN_LATCH_EN
        if (!m_deb[2]) begin
          bit rl, rr;
          rl = m_deb[0] && !m_prev[0];
          rr = m_deb[1] && !m_prev[1];
          if (rl && !rr) m_lat = (m_lat == 1) ? 0 : 1;
          else if (rr && !rl) m_lat = (m_lat == 2) ? 0 : 2;
        end
        nm = m_deb[2] ? 3 : m_lat;
`else
        if (m_deb[2]) nm = 3;
        else if (m_deb[0] != m_deb[1]) nm = m_deb[0] ? 1 : 2;
        else nm = 0;
`endif
        m_chg = (nm != m_mode);
        if (m_chg || nm == 0) begin
          m_since = 0;
          m_tick  = 0;
        end else begin
          m_since++;
          m_tick = (m_since % STEP == 0);
        end
        m_mode = nm;
        m_prev = m_deb;
        // A level changes once the synchronized input has disagreed for DEB samples in a row.
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_deb[i] = ~m_deb[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = pin;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cycle", dut_vec, {m_mode == 1, m_mode == 2, m_mode == 3, m_tick, m_chg});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit3(input string nm, input logic [2:0] exp);
    chk(nm, {sw_if.L, sw_if.R, sw_if.H, 2'b00}, {exp, 2'b00});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    edges(2);
    chk("reset_state", dut_vec, 5'b00000);

`ifdef TURN_LATCH_EN
    @(negedge clk) pin[0] = 1'b1;
    edges(7);
    chk("lat_left_on", dut_vec, 5'b10001);
    repeat (3) @(negedge clk);
    pin[0] = 1'b0;
    edges(20);
    lit3("lat_left_held", 3'b100);
    @(negedge clk) pin[0] = 1'b1;
    edges(7);
    chk("lat_left_off", dut_vec, 5'b00001);
    repeat (3) @(negedge clk);
    pin[0] = 1'b0;
    edges(15);
    @(negedge clk) pin[0] = 1'b1;
    repeat (10) @(negedge clk);
    pin[0] = 1'b0;
    edges(15);
    lit3("lat_left_again", 3'b100);
    @(negedge clk) pin[1] = 1'b1;
    edges(7);
    chk("lat_left_to_right", dut_vec, 5'b01001);
    repeat (3) @(negedge clk);
    pin[1] = 1'b0;
    edges(15);
    @(negedge clk) pin[2] = 1'b1;
    edges(7);
    chk("lat_hazard_on", dut_vec, 5'b00101);
    repeat (3) @(negedge clk);
    pin[2] = 1'b0;
    edges(7);
    chk("lat_right_restored", dut_vec, 5'b01001);
    edges(10);
    @(negedge clk) #2 rst_n = 1'b0;
    #1 chk("lat_async_rst", dut_vec, 5'b00000);
    @(negedge clk) rst_n = 1'b1;
    edges(20);
    chk("lat_post_rst", dut_vec, 5'b00000);
`else
    // 3-cycle glitch is shorter than DEB and must be swallowed
    @(negedge clk) pin[0] = 1'b1;
    repeat (3) @(negedge clk);
    pin[0] = 1'b0;
    edges(12);
    chk("glitch", dut_vec, 5'b00000);

    @(negedge clk) pin[0] = 1'b1;
    edges(6);
    chk("left_pre", dut_vec, 5'b00000);
    edges(1);
    chk("left_on", dut_vec, 5'b10001);
    for (int k = 1; k <= 24; k++) begin
      edges(1);
      if (k % STEP == 0) chk("left_tick", dut_vec, 5'b10010);
    end

    @(negedge clk) pin[2] = 1'b1;
    edges(7);
    chk("haz_on", dut_vec, 5'b00101);
    edges(7);
    chk("haz_no_tick", dut_vec, 5'b00100);
    edges(1);
    chk("haz_tick", dut_vec, 5'b00110);
    @(negedge clk) pin[2] = 1'b0;
    edges(7);
    chk("haz_off", dut_vec, 5'b10001);

    @(negedge clk) pin[1] = 1'b1;
    edges(7);
    chk("both_idle", dut_vec, 5'b00001);
    edges(30);
    chk("both_no_tick", dut_vec, 5'b00000);

    @(negedge clk) pin[0] = 1'b0;
    edges(7);
    chk("right_on", dut_vec, 5'b01001);
    edges(10);
    @(negedge clk) pin[1] = 1'b0;
    edges(7);
    chk("right_off", dut_vec, 5'b00001);
    edges(20);
    chk("right_off_idle", dut_vec, 5'b00000);

    @(negedge clk) pin[0] = 1'b1;
    edges(7);
    chk("left_again", dut_vec, 5'b10001);
    edges(3);
    @(negedge clk) #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_vec, 5'b00000);
    pin = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    edges(20);
    chk("post_rst", dut_vec, 5'b00000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/turn_switch_cond.md
Name: turn_switch_cond

Overview:
- Input-conditioning stage directly upstream of the tail-light sequencer.
- Takes raw, asynchronous left, right and hazard switch levels and synchronizes and debounces them.
- Arbitrates them into one clean mode and drives the sequencer's L, R and H inputs.
- Also produces the step_tick strobe that paces the sequencer's lamp steps, replacing delay-based timing with a counted cycle strobe.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronized samples required before a debounced level changes; legal range 1..65535.
- STEP_CYCLES, 1000: clk cycles between step_tick pulses while a mode is active; legal range 2..2^20.

Ports:
- clk input 1: system clock, rising edge.
- rst_n input 1: asynchronous active-low reset.
- sw_left input 1: raw left-turn switch, asynchronous to clk.
- sw_right input 1: raw right-turn switch, asynchronous to clk.
- sw_hazard input 1: raw hazard switch, asynchronous to clk.
- L output 1: left mode to sequencer, registered.
- R output 1: right mode to sequencer, registered.
- H output 1: hazard mode to sequencer, registered.
- step_tick output 1: one-cycle step strobe, registered.
- mode_chg output 1: one-cycle pulse on the cycle L/R/H change.

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low.
  - rst_n low clears all synchronizers, debounce counters, debounced levels and the tick counter.
  - It forces state IDLE, and L=R=H=0, step_tick=0, mode_chg=0.
  - Reset mid-sequence takes effect immediately, with no completion of the current step.
- Synchronizer: two flops per switch input. The synchronized value lags the pin by 2 cycles.
- Debounce, per input:
  - A counter increments while the synchronized value differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - Total pin-to-debounced latency for a clean edge is 2+DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles produces no change.
- Mode FSM, states IDLE, LEFT, RIGHT, HAZARD. It is evaluated every cycle from the debounced levels dh, dl, dr:
  - dh=1 -> HAZARD. Hazard has the highest priority regardless of dl/dr.
  - dh=0, dl=1, dr=0 -> LEFT.
  - dh=0, dl=0, dr=1 -> RIGHT.
  - dh=0 and dl=dr, whether both 0 or both 1 -> IDLE. Both-on is an illegal switch combination and yields idle, not hazard.
- Outputs:
  - L=1 only in LEFT, R=1 only in RIGHT, H=1 only in HAZARD. They are one-hot or all zero and never overlap.
  - Outputs are registered, so L/R/H follow a debounced change by 1 cycle.
  - mode_chg is high for exactly the cycle in which the registered L/R/H value differs from its previous value.
- Step tick:
  - In IDLE the tick counter is held at 0 and step_tick=0.
  - On any mode change the counter restarts at 0, with no tick in that cycle.
  - While in a non-IDLE state the counter counts 0..STEP_CYCLES-1 and wraps.
  - step_tick=1 in the cycle after the counter equals STEP_CYCLES-1, so the first tick comes STEP_CYCLES cycles after mode_chg, then every STEP_CYCLES cycles.
  - A tick is never emitted in the same cycle as mode_chg.
- Simultaneous events: if two debounced levels flip on the same edge, the FSM resolves priority in that single cycle. No transient intermediate mode is ever output.

Optional Feature:
- Macro TURN_LATCH_EN.
- Defined: left and right switches act as momentary push-buttons.
  - A debounced rising edge of sw_left enters LEFT from IDLE or RIGHT, and returns LEFT to IDLE.
  - sw_right behaves symmetrically.
  - Coincident debounced rising edges of left and right are ignored.
  - Hazard remains level-driven and overrides. On hazard release the FSM returns to the latched turn state held before the hazard.
  - Reset clears the latch.
- Undefined: level-following behaviour exactly as in Behaviour above, with no latch storage.

Test Plan:
All scenarios use a bench with DEB_CYCLES=4 and STEP_CYCLES=8.
1. Reset: rst_n=0 asynchronously mid-LEFT -> L=R=H=0, step_tick=0 without waiting for a clk edge; after release, all outputs stay 0 with switches low.
2. Left debounce: sw_left 0->1, held -> L=1 and mode_chg=1 exactly 2+4+1=7 cycles after the pin edge; step_tick pulses 8, 16 and 24 cycles after mode_chg; a 3-cycle glitch on sw_left produces no change.
3. Priority: sw_left=1 steady, then sw_hazard=1 -> L drops and H rises in the same cycle, one mode_chg pulse, tick counter restarted (next tick 8 cycles later); hazard released -> back to L=1.
4. Illegal combination: sw_left=1 and sw_right=1, with sw_hazard=0 -> L=R=H=0, step_tick stays 0 indefinitely.
5. Right release: R active, sw_right 1->0 -> R=0 after 7 cycles, step_tick held 0 from then on, counter at 0.
6. TURN_LATCH_EN: 10-cycle press on sw_left -> L=1 stays after release; a second press -> L=0; press left then right -> L->0 and R->1 in one cycle; hazard pulse during R -> H, then R restored.
